// File: rtl/seg7_scan_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver_if : digit/control inputs and display pins of the driver  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface seg7_scan_driver_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       set_time;
  logic [1:0] sel;
  logic       blank_lz;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  // Counter chain / control side drives digits, display side consumes pins.
  modport master (
    output digit0, digit1, digit2, digit3, set_time, sel, blank_lz,
    input  an_n, seg_n, dp_n
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, set_time, sel, blank_lz,
    output an_n, seg_n, dp_n
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver : 4-digit common-anode multiplexed 7-seg scan with blink   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  wire logic          clkmain,
  input  wire logic          clear_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int c_PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
  localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(BLINK_DIV - 1);

  logic [c_PW-1:0] r_presc;
  logic [1:0]      r_ptr;
  logic [c_FW-1:0] r_frame;
  logic            r_blink;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_tick;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg;
  logic            w_blank;

  assign w_tick = (r_presc == c_PRESC_LAST);

  always_comb begin
    w_digit = bus.digit0;
    case (r_ptr)
      2'd0:    w_digit = bus.digit0;
      2'd1:    w_digit = bus.digit1;
      2'd2:    w_digit = bus.digit2;
      default: w_digit = bus.digit3;
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, active low; non-BCD codes show a dash.
  always_comb begin
    w_seg = 7'b0111111;
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  assign w_blank = (bus.set_time && (bus.sel == r_ptr) && r_blink) ||
                   (bus.blank_lz && (r_ptr == 2'd3) && (bus.digit3 == 4'd0));

  always_ff @(posedge clkmain) begin
    if (!clear_n) begin
      r_presc <= '0;
      r_ptr   <= 2'd0;
      r_frame <= '0;
      r_blink <= 1'b0;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
      r_dp    <= 1'b1;
    end else if (w_tick) begin
      r_presc <= '0;
      r_ptr   <= r_ptr + 2'd1;
      r_an    <= w_blank ? 4'b1111 : ~(4'b0001 << r_ptr);
      r_seg   <= w_blank ? 7'b1111111 : w_seg;
      r_dp    <= !((r_ptr == 2'd2) && !w_blank);
      // Blink phase advances after the slot has used its current value.
      if (r_ptr == 2'd3) begin
        if (r_frame == c_FRAME_LAST) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + c_FW'(1);
        end
      end
    end else begin
      r_presc <= r_presc + c_PW'(1);
    end
  end

  assign bus.an_n  = r_an;
  assign bus.seg_n = r_seg;
  assign bus.dp_n  = r_dp;

endmodule
`default_nettype wire
